// File: rtl/ddr3_arb_pkg.sv
// Shared types for the DDR3 port arbiter: FSM states, controller command codes
// and the request record captured at grant time.
package ddr3_arb_pkg;

    localparam int ARB_AW = 29;
    localparam int ARB_DW = 128;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        DONE
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef struct packed {
        logic                  we;
        logic [ARB_AW-1:0]     adr;
        logic [ARB_DW/8-1:0]   sel;
        logic [ARB_DW-1:0]     dat_w;
    } req_t;

endpackage

// File: rtl/ddr3_port_arbiter_rr_picker.sv
// Rotating priority encoder: first requester above the last winner, wrapping.
// DDR3_ARB_VIDEO_PRIO_EN lets port 0 pre-empt the rotation whenever it requests.
module rr_picker #(
    parameter int NPORTS = 4,
    parameter int IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last,
    output logic [IW-1:0]     winner,
    output logic              valid
);

    int idx;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Walk offsets from farthest to nearest so the nearest requester is written last.
        for (int i = NPORTS; i >= 1; i--) begin
            idx = (int'(last) + i) % NPORTS;
            if (req[idx]) begin
                winner = idx[IW-1:0];
                valid  = 1'b1;
            end
        end
`ifdef DDR3_ARB_VIDEO_PRIO_EN
        if (req[0]) begin
            winner = '0;
            valid  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller app interface among NPORTS requesters.
// Optional build macro DDR3_ARB_VIDEO_PRIO_EN gives port 0 (video fetch) absolute priority.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int AW        = ARB_AW,
    parameter int DW        = ARB_DW,
    parameter int TO_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NPORTS-1:0]            req,
    input  logic [NPORTS-1:0]            we,
    input  logic [NPORTS-1:0][AW-1:0]    adr,
    input  logic [NPORTS-1:0][DW/8-1:0]  sel,
    input  logic [NPORTS-1:0][DW-1:0]    dat_w,
    output logic [NPORTS-1:0]            ack,
    output logic [NPORTS-1:0]            err,
    output logic [DW-1:0]                dat_r,
    output logic                         app_en,
    output logic [2:0]                   app_cmd,
    output logic [AW-1:0]                app_addr,
    input  logic                         app_rdy,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    output logic [DW-1:0]                app_wdf_data,
    output logic [DW/8-1:0]              app_wdf_mask,
    input  logic                         app_wdf_rdy,
    input  logic [DW-1:0]                app_rd_data,
    input  logic                         app_rd_data_valid,
    output logic                         busy
);

    localparam int IW = $clog2(NPORTS);
    localparam int CW = $clog2(TO_CYCLES + 1);

    // The latched request record is sized by the package geometry.
    if (AW != ARB_AW || DW != ARB_DW) begin : g_geometry_check
        $error("ddr3_port_arbiter: AW/DW must match ddr3_arb_pkg geometry");
    end

    state_t        state, next_state;
    req_t          lreq;
    logic [IW-1:0] last, winner, pick_idx;
    logic          pick_valid;
    logic          cmd_done, wdf_done, cmd_acc, wdf_acc;
    logic          timeout_hit, err_flag;
    logic [CW-1:0] to_cnt;

    rr_picker #(.NPORTS(NPORTS), .IW(IW)) u_picker (
        .req    (req),
        .last   (last),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        next_state   = state;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        cmd_acc      = 1'b0;
        wdf_acc      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: if (pick_valid) next_state = we[pick_idx] ? WR : RD;
            WR: begin
                app_en       = !cmd_done;
                app_wdf_wren = !wdf_done;
                cmd_acc      = app_en && app_rdy;
                wdf_acc      = app_wdf_wren && app_wdf_rdy;
                if ((cmd_done || cmd_acc) && (wdf_done || wdf_acc)) next_state = DONE;
                else if (to_cnt == CW'(TO_CYCLES - 1)) begin
                    next_state  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            RD: begin
                app_en = 1'b1;
                if (app_rdy) next_state = RWAIT;
                else if (to_cnt == CW'(TO_CYCLES - 1)) begin
                    next_state  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            RWAIT: begin
                if (app_rd_data_valid) next_state = DONE;
                else if (to_cnt == CW'(TO_CYCLES - 1)) begin
                    next_state  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lreq     <= '0;
            winner   <= '0;
            last     <= IW'(NPORTS - 1);
            cmd_done <= 1'b0;
            wdf_done <= 1'b0;
            to_cnt   <= '0;
            err_flag <= 1'b0;
            dat_r    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && pick_valid) begin
                winner     <= pick_idx;
                lreq.we    <= we[pick_idx];
                lreq.adr   <= adr[pick_idx];
                lreq.sel   <= sel[pick_idx];
                lreq.dat_w <= dat_w[pick_idx];
            end
            if (state == IDLE) begin
                cmd_done <= 1'b0;
                wdf_done <= 1'b0;
            end else begin
                if (cmd_acc) cmd_done <= 1'b1;
                if (wdf_acc) wdf_done <= 1'b1;
            end
            // The timeout window restarts whenever a waiting state is entered.
            if (next_state != state) to_cnt <= '0;
            else if (state == WR || state == RD || state == RWAIT) to_cnt <= to_cnt + CW'(1);
            if (next_state == DONE) err_flag <= timeout_hit;
            if (state == RWAIT && app_rd_data_valid) dat_r <= app_rd_data;
            if (state == DONE) begin
`ifdef DDR3_ARB_VIDEO_PRIO_EN
                if (winner != '0) last <= winner;
`else
                last <= winner;
`endif
            end
        end
    end

    always_comb begin
        ack = '0;
        err = '0;
        if (state == DONE) begin
            ack[winner] = 1'b1;
            err[winner] = err_flag;
        end
    end

    assign busy         = (state != IDLE);
    assign app_cmd      = (busy && !lreq.we) ? CMD_READ : CMD_WRITE;
    assign app_addr     = lreq.adr;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = lreq.dat_w;
    assign app_wdf_mask = app_wdf_wren ? ~lreq.sel : '0;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: transaction-level model compared every
// cycle, plus directed latency/order checks. Honours DDR3_ARB_VIDEO_PRIO_EN.
module tb_ddr3_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 29;
    localparam int DW = 128;
    localparam int TO = 40;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic [NP-1:0]             req, we;
    logic [NP-1:0][AW-1:0]     adr;
    logic [NP-1:0][DW/8-1:0]   sel;
    logic [NP-1:0][DW-1:0]     dat_w;
    logic [NP-1:0]             ack, err;
    logic [DW-1:0]             dat_r;
    logic                      app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [2:0]                app_cmd;
    logic [AW-1:0]             app_addr;
    logic [DW-1:0]             app_wdf_data, app_rd_data;
    logic [DW/8-1:0]           app_wdf_mask;
    logic                      app_rd_data_valid, busy;

    ddr3_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req               (req),
        .we                (we),
        .adr               (adr),
        .sel               (sel),
        .dat_w             (dat_w),
        .ack               (ack),
        .err               (err),
        .dat_r             (dat_r),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rdy           (app_rdy),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic              exp_en, exp_wren, exp_busy;
    logic [NP-1:0]     exp_ack, exp_err;
    logic [2:0]        exp_cmd;
    logic [AW-1:0]     exp_addr;
    logic [DW-1:0]     exp_wdata, exp_dat_r;
    logic [DW/8-1:0]   exp_mask;
    int                m_last;

    function automatic int pick(input logic [NP-1:0] r, input int last);
        int p;
`ifdef DDR3_ARB_VIDEO_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int i = 1; i <= NP; i++) begin
            p = (last + i) % NP;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    initial begin
        int w, cnt;
        bit wr, to, cd, wd;
        exp_en = 0; exp_wren = 0; exp_busy = 0; exp_ack = '0; exp_err = '0;
        exp_cmd = 3'b000; exp_addr = '0; exp_wdata = '0; exp_dat_r = '0; exp_mask = '0;
        m_last = NP - 1;
        wait (resetn === 1'b1);
        forever begin
            exp_busy = 0; exp_en = 0; exp_wren = 0; exp_ack = '0; exp_err = '0;
            @(posedge clk);
            w = pick(req, m_last);
            if (w < 0) continue;
            wr = we[w]; exp_addr = adr[w]; exp_mask = ~sel[w]; exp_wdata = dat_w[w];
            exp_cmd = wr ? 3'b000 : 3'b001;
            exp_busy = 1; to = 0; cnt = 0;
            if (wr) begin
                cd = 0; wd = 0;
                forever begin
                    exp_en = !cd; exp_wren = !wd;
                    @(posedge clk);
                    if (app_rdy) cd = 1;
                    if (app_wdf_rdy) wd = 1;
                    if (cd && wd) break;
                    cnt++;
                    if (cnt == TO) begin to = 1; break; end
                end
            end else begin
                exp_en = 1;
                forever begin
                    @(posedge clk);
                    if (app_rdy) break;
                    cnt++;
                    if (cnt == TO) begin to = 1; break; end
                end
                if (!to) begin
                    exp_en = 0; cnt = 0;
                    forever begin
                        @(posedge clk);
                        if (app_rd_data_valid) begin exp_dat_r = app_rd_data; break; end
                        cnt++;
                        if (cnt == TO) begin to = 1; break; end
                    end
                end
            end
            exp_en = 0; exp_wren = 0;
            exp_ack = '0; exp_ack[w] = 1'b1;
            exp_err = to ? exp_ack : '0;
            @(posedge clk);
`ifdef DDR3_ARB_VIDEO_PRIO_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
        end
    end

    task automatic compare_outputs();
        check("busy", 128'(busy), 128'(exp_busy));
        check("ack", 128'(ack), 128'(exp_ack));
        check("err", 128'(err), 128'(exp_err));
        check("dat_r", dat_r, exp_dat_r);
        check("app_en", 128'(app_en), 128'(exp_en));
        check("app_wdf_wren", 128'(app_wdf_wren), 128'(exp_wren));
        check("app_wdf_end", 128'(app_wdf_end), 128'(exp_wren));
        if (exp_en) begin
            check("app_cmd", 128'(app_cmd), 128'(exp_cmd));
            check("app_addr", 128'(app_addr), 128'(exp_addr));
        end
        if (exp_wren) begin
            check("app_wdf_data", app_wdf_data, exp_wdata);
            check("app_wdf_mask", 128'(app_wdf_mask), 128'(exp_mask));
        end
    endtask

    // ---------------- directed stimulus ----------------
    // Starts on a negedge with the arbiter idle; k counts negedges after req is raised.
    task automatic run_txn(input int p, input bit wr, input logic [AW-1:0] a,
                           input logic [DW/8-1:0] s, input logic [DW-1:0] d,
                           input int rdy_at, input int wdf_at, input int valid_at,
                           input logic [DW-1:0] rdata, input int drop_at,
                           output int ack_k, output bit err_k);
        we[p] = wr; adr[p] = a; sel[p] = s; dat_w[p] = d; req[p] = 1'b1;
        app_rdy = (rdy_at <= 0); app_wdf_rdy = (wdf_at <= 0);
        ack_k = -1; err_k = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            app_rdy = (k >= rdy_at);
            app_wdf_rdy = (k >= wdf_at);
            app_rd_data_valid = (k == valid_at);
            app_rd_data = (k == valid_at) ? rdata : '0;
            if (k == 2) begin adr[p] = ~a; sel[p] = ~s; dat_w[p] = ~d; end
            if (k == drop_at) req[p] = 1'b0;
            if (ack[p]) begin
                ack_k = k; err_k = err[p]; req[p] = 1'b0;
                break;
            end
        end
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0; app_rd_data = '0;
    endtask

    initial begin
        int k_ack;
        bit e_ack;
        int got[$];
        int exp_order[5];
        int exp_prio[4];
`ifdef DDR3_ARB_VIDEO_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
        exp_prio  = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
        exp_prio  = '{0, 3, 0, 3};
`endif
        resetn = 0; req = '0; we = '0; adr = '0; sel = '0; dat_w = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;
        fork
            forever begin
                @(negedge clk);
                compare_outputs();
            end
        join_none

        for (int i = 0; i < NP; i++) begin
            we[i] = 1'b1;
            adr[i] = AW'(i * 64);
            sel[i] = 16'h00FF << i;
            dat_w[i] = {4{32'hC0DE_0000 + 32'(i)}};
        end
        req = '1;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_app_en", 128'(app_en), 128'(0));
        check("reset_ack", 128'(ack), 128'(0));
        resetn = 1;

        // All ports requesting continuously from reset.
        for (int k = 0; k < 100 && got.size() < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) if (ack[i]) got.push_back(i);
            if (got.size() >= 5) req = '0;
        end
        check("contention_ack_count", 128'(got.size()), 128'(5));
        for (int i = 0; i < got.size() && i < 5; i++)
            check($sformatf("contention_order[%0d]", i), 128'(got[i]), 128'(exp_order[i]));
        @(negedge clk);

        run_txn(1, 1'b1, 29'h100, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                0, 0, -1, '0, -1, k_ack, e_ack);
        check("single_write_ack_cycle", 128'(k_ack), 128'(2));
        check("single_write_err", 128'(e_ack), 128'(0));
        @(negedge clk);

        run_txn(2, 1'b0, 29'h200, 16'hFFFF, '0, 0, 0, 21, 128'hDEADBEEF, -1, k_ack, e_ack);
        check("single_read_ack_cycle", 128'(k_ack), 128'(22));
        check("single_read_dat_r", dat_r, 128'hDEADBEEF);
        @(negedge clk);

        run_txn(0, 1'b0, 29'h300, 16'hFFFF, '0, 0, 0, -1, '0, -1, k_ack, e_ack);
        check("read_timeout_ack_cycle", 128'(k_ack), 128'(TO + 2));
        check("read_timeout_err", 128'(e_ack), 128'(1));
        check("read_timeout_dat_r_kept", dat_r, 128'hDEADBEEF);
        @(negedge clk);

        run_txn(1, 1'b1, 29'h400, 16'h0F0F, 128'h5555, 1, 1000, -1, '0, -1, k_ack, e_ack);
        check("write_timeout_ack_cycle", 128'(k_ack), 128'(TO + 1));
        check("write_timeout_err", 128'(e_ack), 128'(1));
        @(negedge clk);

        // Split handshake; requester also drops req mid-transaction.
        run_txn(3, 1'b1, 29'h1ABC, 16'hA5A5, 128'hCAFE_F00D, 2, 7, -1, '0, 3, k_ack, e_ack);
        check("split_write_ack_cycle", 128'(k_ack), 128'(8));
        check("split_write_err", 128'(e_ack), 128'(0));
        repeat (3) begin
            @(negedge clk);
            check("split_write_no_extra_ack", 128'(ack), 128'(0));
        end

        got.delete();
        we[0] = 1'b1; we[3] = 1'b1;
        req = 4'b1001;
        for (int k = 0; k < 100 && got.size() < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) if (ack[i]) got.push_back(i);
            if (got.size() >= 4) req = '0;
        end
        check("priority_ack_count", 128'(got.size()), 128'(4));
        for (int i = 0; i < got.size() && i < 4; i++)
            check($sformatf("priority_order[%0d]", i), 128'(got[i]), 128'(exp_prio[i]));
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
